// File: rtl/cpu_stack_pkg.sv
// ---------------------------------------------------------------------------
// cpu_stack_pkg
// Shared definitions for the CPU operand-stack sequencer:
//   - high-level operation codes (OP_LOAD .. OP_ROT) carried on Op
//   - primitive stack task codes (TASK_STORE .. TASK_SWAP) driven on Task
//   - sequencer state enumeration
//   - default number of stack entries
// ---------------------------------------------------------------------------
package cpu_stack_pkg;

    localparam int DEPTH_DEFAULT = 8;

    // High-level operations requested by the CPU core
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_PUSH   = 3'b001;
    localparam logic [2:0] OP_POP    = 3'b010;
    localparam logic [2:0] OP_DUP    = 3'b011;
    localparam logic [2:0] OP_OVER   = 3'b100;
    localparam logic [2:0] OP_SWAP   = 3'b101;
    localparam logic [2:0] OP_REDUCE = 3'b110;
    localparam logic [2:0] OP_ROT    = 3'b111;

    // Primitive commands understood by the stack
    localparam logic [1:0] TASK_STORE = 2'b00;
    localparam logic [1:0] TASK_PUSH  = 2'b01;
    localparam logic [1:0] TASK_POP   = 2'b10;
    localparam logic [1:0] TASK_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_GAP1   = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_GAP2   = 3'd4
    } state_e;

endpackage

// File: rtl/cpu_stack_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_stack_sequencer_if
// Bundles the CPU-side request/response handshake and the stack-side
// primitive command bus of the sequencer.
//   CPU side   : Valid, Ready, Op, Data, Idx, Done, Error, RdData, Depth
//   Stack side : StackOut0, StackOut1 (stack s0/s1), Latch, Task, Address,
//                StackIn
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding environment (CPU core plus stack)
// ---------------------------------------------------------------------------
interface cpu_stack_sequencer_if;

    logic       Valid;
    logic       Ready;
    logic [2:0] Op;
    logic [7:0] Data;
    logic [2:0] Idx;
    logic       Done;
    logic       Error;
    logic [7:0] RdData;
    logic [3:0] Depth;
    logic [7:0] StackOut0;
    logic [7:0] StackOut1;
    logic       Latch;
    logic [1:0] Task;
    logic [2:0] Address;
    logic [7:0] StackIn;

    modport slave (
        input  Valid, Op, Data, Idx, StackOut0, StackOut1,
        output Ready, Done, Error, RdData, Depth, Latch, Task, Address, StackIn
    );

    modport master (
        output Valid, Op, Data, Idx, StackOut0, StackOut1,
        input  Ready, Done, Error, RdData, Depth, Latch, Task, Address, StackIn
    );

endinterface

// File: rtl/cpu_stack_depth_guard.sv
// ---------------------------------------------------------------------------
// cpu_stack_depth_guard
// Occupancy counter of the controlled stack plus combinational legality
// check for an operation about to be accepted.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset (depth -> 0)
//   check_op    - operation presented for acceptance
//   check_idx   - SWAP index presented for acceptance
//   commit      - one-cycle pulse when an accepted operation completes
//   commit_op   - operation being completed
//   depth       - current occupancy 0..DEPTH
//   legal       - check_op/check_idx may be executed at the current depth
// ---------------------------------------------------------------------------
module cpu_stack_depth_guard
    import cpu_stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] check_op,
    input  logic [2:0] check_idx,
    input  logic       commit,
    input  logic [2:0] commit_op,
    output logic [3:0] depth,
    output logic       legal
);

    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    logic [3:0] depth_r;
    logic [3:0] depth_nxt_s;
    logic [3:0] idx_ext_s;
    logic       legal_s;

    assign idx_ext_s = {1'b0, check_idx};

    // Legality of the presented operation against the current occupancy
    always_comb begin
        legal_s = 1'b0;
        case (check_op)
            OP_LOAD:   legal_s = 1'b1;
            OP_PUSH:   legal_s = (depth_r < DEPTH_MAX);
            OP_POP:    legal_s = (depth_r >= 4'd1);
            OP_DUP:    legal_s = (depth_r >= 4'd1) && (depth_r < DEPTH_MAX);
            OP_OVER:   legal_s = (depth_r >= 4'd2) && (depth_r < DEPTH_MAX);
            OP_SWAP:   legal_s = (idx_ext_s >= 4'd1) && (idx_ext_s < depth_r);
            OP_REDUCE: legal_s = (depth_r >= 4'd2);
            OP_ROT:    legal_s = (depth_r >= 4'd3);
            default:   legal_s = 1'b0;
        endcase
    end

    // Occupancy after the completing operation
    always_comb begin
        depth_nxt_s = depth_r;
        if (commit) begin
            case (commit_op)
                // STORE creates s0 on an empty stack, otherwise overwrites it
                OP_LOAD:   depth_nxt_s = (depth_r == 4'd0) ? 4'd1 : depth_r;
                OP_PUSH,
                OP_DUP,
                OP_OVER:   depth_nxt_s = depth_r + 4'd1;
                OP_POP,
                OP_REDUCE: depth_nxt_s = depth_r - 4'd1;
                OP_SWAP,
                OP_ROT:    depth_nxt_s = depth_r;
                default:   depth_nxt_s = depth_r;
            endcase
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    // Occupancy register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            depth_r <= 4'd0;
        end else begin
            depth_r <= depth_nxt_s;
        end
    end

    assign depth = depth_r;
    assign legal = legal_s;

endmodule

// File: rtl/cpu_stack_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_stack_sequencer
// Accepts one high-level stack operation at a time (Valid/Ready) and expands
// it into one primitive stack command (two for ROT). Each primitive is a
// single-cycle Latch pulse with Task/Address/StackIn held stable; a GAP cycle
// follows every pulse so Latch is low again before the next rising edge.
// The stack samples on the falling edge of the same Clk.
// Ports:
//   Clk    - system clock (sequencer acts on posedge)
//   Reset  - synchronous active-high reset
//   bus    - cpu_stack_sequencer_if.slave: CPU handshake and stack bus
// Build option:
//   CPU_STACK_GUARD_EN - when defined, tracks Depth and rejects illegal
//                        operations (Done with Error, stack untouched).
//                        When undefined every operation is executed, Error
//                        never rises and Depth reads 0.
// ---------------------------------------------------------------------------
module cpu_stack_sequencer
    import cpu_stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    cpu_stack_sequencer_if.slave  bus
);

    // Depth is reported on 4 bits
    if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
        $error("cpu_stack_sequencer: DEPTH must be in 1..15");
    end

    state_e     state_r;
    state_e     state_nxt_s;

    logic [2:0] op_r,     op_nxt_s;
    logic       latch_r,  latch_nxt_s;
    logic       ready_r,  ready_nxt_s;
    logic       done_r,   done_nxt_s;
    logic       error_r,  error_nxt_s;
    logic [7:0] rd_r,     rd_nxt_s;
    logic [1:0] task_r,   task_nxt_s;
    logic [2:0] addr_r,   addr_nxt_s;
    logic [7:0] stkin_r,  stkin_nxt_s;

    logic       accept_s;
    logic       legal_s;

    assign accept_s = bus.Valid && (state_r == ST_IDLE);

`ifdef CPU_STACK_GUARD_EN
    logic       commit_s;
    logic [3:0] depth_s;

    // Final primitive of a legal operation is being latched this cycle
    assign commit_s = ((state_r == ST_ISSUE1) && (op_r != OP_ROT)) ||
                      (state_r == ST_ISSUE2);

    cpu_stack_depth_guard #(
        .DEPTH     (DEPTH)
    ) u_depth_guard (
        .Clk       (Clk),
        .Reset     (Reset),
        .check_op  (bus.Op),
        .check_idx (bus.Idx),
        .commit    (commit_s),
        .commit_op (op_r),
        .depth     (depth_s),
        .legal     (legal_s)
    );

    assign bus.Depth = depth_s;
`else
    assign legal_s   = 1'b1;
    assign bus.Depth = 4'd0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // Rejected ops skip the primitives and finish via GAP2
                    state_nxt_s = legal_s ? ST_ISSUE1 : ST_GAP2;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE1: state_nxt_s = ST_GAP1;
            ST_GAP1: begin
                if (op_r == OP_ROT) begin
                    state_nxt_s = ST_ISSUE2;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE2: state_nxt_s = ST_GAP2;
            ST_GAP2:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of all registered outputs
    always_comb begin
        op_nxt_s    = op_r;
        rd_nxt_s    = rd_r;
        task_nxt_s  = task_r;
        addr_nxt_s  = addr_r;
        stkin_nxt_s = stkin_r;
        done_nxt_s  = 1'b0;
        error_nxt_s = 1'b0;
        latch_nxt_s = (state_nxt_s == ST_ISSUE1) || (state_nxt_s == ST_ISSUE2);
        ready_nxt_s = (state_nxt_s == ST_IDLE);

        if (accept_s) begin
            op_nxt_s = bus.Op;
            rd_nxt_s = bus.StackOut0;
            if (legal_s) begin
                // Command bus only moves when a primitive is about to issue
                case (bus.Op)
                    OP_LOAD: begin
                        task_nxt_s  = TASK_STORE;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.Data;
                    end
                    OP_PUSH: begin
                        task_nxt_s  = TASK_PUSH;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.Data;
                    end
                    OP_POP: begin
                        // s1 is written back into s0 while the stack shifts up
                        task_nxt_s  = TASK_POP;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.StackOut1;
                    end
                    OP_DUP: begin
                        task_nxt_s  = TASK_PUSH;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.StackOut0;
                    end
                    OP_OVER: begin
                        task_nxt_s  = TASK_PUSH;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.StackOut1;
                    end
                    OP_SWAP: begin
                        task_nxt_s  = TASK_SWAP;
                        addr_nxt_s  = bus.Idx;
                        stkin_nxt_s = stkin_r;
                    end
                    OP_REDUCE: begin
                        // Pops two operands, result replaces them as s0
                        task_nxt_s  = TASK_POP;
                        addr_nxt_s  = 3'd0;
                        stkin_nxt_s = bus.Data;
                    end
                    OP_ROT: begin
                        // swap(s0,s1) then swap(s0,s2)
                        task_nxt_s  = TASK_SWAP;
                        addr_nxt_s  = 3'd1;
                        stkin_nxt_s = stkin_r;
                    end
                    default: begin
                        task_nxt_s  = task_r;
                        addr_nxt_s  = addr_r;
                        stkin_nxt_s = stkin_r;
                    end
                endcase
            end else begin
                done_nxt_s  = 1'b1;
                error_nxt_s = 1'b1;
            end
        end else if ((state_r == ST_GAP1) && (op_r == OP_ROT)) begin
            task_nxt_s = TASK_SWAP;
            addr_nxt_s = 3'd2;
        end else if (((state_r == ST_ISSUE1) && (op_r != OP_ROT)) ||
                     (state_r == ST_ISSUE2)) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_r    <= OP_LOAD;
            latch_r <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            rd_r    <= 8'd0;
            task_r  <= TASK_STORE;
            addr_r  <= 3'd0;
            stkin_r <= 8'd0;
        end else begin
            op_r    <= op_nxt_s;
            latch_r <= latch_nxt_s;
            ready_r <= ready_nxt_s;
            done_r  <= done_nxt_s;
            error_r <= error_nxt_s;
            rd_r    <= rd_nxt_s;
            task_r  <= task_nxt_s;
            addr_r  <= addr_nxt_s;
            stkin_r <= stkin_nxt_s;
        end
    end

    assign bus.Ready   = ready_r;
    assign bus.Done    = done_r;
    assign bus.Error   = error_r;
    assign bus.RdData  = rd_r;
    assign bus.Latch   = latch_r;
    assign bus.Task    = task_r;
    assign bus.Address = addr_r;
    assign bus.StackIn = stkin_r;

endmodule

// File: tb/tb_cpu_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_stack_sequencer
// Drives cpu_stack_sequencer with directed operations against a behavioural
// 8-entry stack that samples the primitive bus on the falling clock edge.
// Expected results are hand-computed; Depth/Error expectations follow the
// CPU_STACK_GUARD_EN build option.
// ---------------------------------------------------------------------------
module tb_cpu_stack_sequencer;

    logic Clk;
    logic Reset;

    cpu_stack_sequencer_if bus ();

    cpu_stack_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural operand stack
    logic [7:0] stk [8];

    assign bus.StackOut0 = stk[0];
    assign bus.StackOut1 = stk[1];

    always @(negedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) stk[i] <= 8'h00;
        end else if (bus.Latch) begin
            case (bus.Task)
                2'b00: stk[0] <= bus.StackIn;
                2'b01: begin
                    for (int i = 7; i > 0; i--) stk[i] <= stk[i-1];
                    stk[0] <= bus.StackIn;
                end
                2'b10: begin
                    for (int i = 0; i < 7; i++) stk[i] <= stk[i+1];
                    stk[7] <= 8'h00;
                    stk[0] <= bus.StackIn;
                end
                2'b11: begin
                    stk[0]           <= stk[bus.Address];
                    stk[bus.Address] <= stk[0];
                end
                default: ;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dx(input logic [3:0] d);
`ifdef CPU_STACK_GUARD_EN
        return d;
`else
        return 4'd0;
`endif
    endfunction

    // Masks over cycles k+1..k+5 after the accept edge k (bit0 = k+1)
    localparam logic [4:0] L1 = 5'b00001, D1 = 5'b00010, R1 = 5'b11100;
    localparam logic [4:0] LR = 5'b00101, DR = 5'b01000, RR = 5'b10000;
    localparam logic [4:0] LX = 5'b00000, DX = 5'b00001, EX = 5'b00001, RX = 5'b11110;
    localparam logic [4:0] E0 = 5'b00000;

    typedef struct {
        logic       rst_first;
        logic [2:0] op;
        logic [7:0] data;
        logic [2:0] idx;
        logic [4:0] lat;
        logic [4:0] done;
        logic [4:0] err;
        logic [4:0] rdy;
        logic [7:0] rd;
        logic [3:0] depth;
        logic [7:0] s0, s1, s2;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rf, input logic [2:0] op, input logic [7:0] data,
                                input logic [2:0] idx, input logic [4:0] lat, input logic [4:0] done,
                                input logic [4:0] err, input logic [4:0] rdy, input logic [7:0] rd,
                                input logic [3:0] depth, input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] s2);
        vec_t v;
        v.rst_first = rf; v.op = op; v.data = data; v.idx = idx;
        v.lat = lat; v.done = done; v.err = err; v.rdy = rdy;
        v.rd = rd; v.depth = depth; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        return v;
    endfunction

    task automatic do_reset();
        Reset     = 1'b1;
        bus.Valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset  = 1'b0;
    endtask

    // Issues one operation (caller sits at posedge+1) and samples 5 cycles
    task automatic run_op(input logic [2:0] op, input logic [7:0] data, input logic [2:0] idx,
                          output logic [4:0] lat_m, output logic [4:0] done_m,
                          output logic [4:0] err_m, output logic [4:0] rdy_m,
                          output logic [7:0] rd_got);
        int n = 0;
        lat_m = 5'd0; done_m = 5'd0; err_m = 5'd0; rdy_m = 5'd0; rd_got = 8'h00;
        while (bus.Ready !== 1'b1 && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, bus.Ready}, 32'd1);
        bus.Valid = 1'b1; bus.Op = op; bus.Data = data; bus.Idx = idx;
        @(posedge Clk); #1;
        // Later changes on the request lines must be ignored
        bus.Valid = 1'b0; bus.Op = ~op; bus.Data = ~data; bus.Idx = ~idx;
        for (int c = 0; c < 5; c++) begin
            lat_m[c]  = bus.Latch;
            done_m[c] = bus.Done;
            err_m[c]  = bus.Error;
            rdy_m[c]  = bus.Ready;
            if (bus.Done === 1'b1) rd_got = bus.RdData;
            if (c < 4) begin
                @(posedge Clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] lat_m, done_m, err_m, rdy_m;
        logic [7:0] rd_got;
        int         lat_cnt;

        //            rf    op         data   idx   lat done err rdy  rd     depth     s0     s1     s2
        vecs[0]  = mk(1'b0, 3'b001, 8'h11, 3'd0, L1, D1, E0, R1, 8'h00, dx(4'd1), 8'h11, 8'h00, 8'h00);
        vecs[1]  = mk(1'b0, 3'b001, 8'h22, 3'd0, L1, D1, E0, R1, 8'h11, dx(4'd2), 8'h22, 8'h11, 8'h00);
        vecs[2]  = mk(1'b0, 3'b001, 8'h33, 3'd0, L1, D1, E0, R1, 8'h22, dx(4'd3), 8'h33, 8'h22, 8'h11);
        vecs[3]  = mk(1'b0, 3'b111, 8'h00, 3'd0, LR, DR, E0, RR, 8'h33, dx(4'd3), 8'h11, 8'h33, 8'h22);
        vecs[4]  = mk(1'b0, 3'b010, 8'h00, 3'd0, L1, D1, E0, R1, 8'h11, dx(4'd2), 8'h33, 8'h22, 8'h00);
        vecs[5]  = mk(1'b0, 3'b011, 8'h00, 3'd0, L1, D1, E0, R1, 8'h33, dx(4'd3), 8'h33, 8'h33, 8'h22);
        vecs[6]  = mk(1'b0, 3'b101, 8'h00, 3'd2, L1, D1, E0, R1, 8'h33, dx(4'd3), 8'h22, 8'h33, 8'h33);
        vecs[7]  = mk(1'b0, 3'b100, 8'h00, 3'd0, L1, D1, E0, R1, 8'h22, dx(4'd4), 8'h33, 8'h22, 8'h33);
        vecs[8]  = mk(1'b0, 3'b110, 8'h5A, 3'd0, L1, D1, E0, R1, 8'h33, dx(4'd3), 8'h5A, 8'h33, 8'h33);
        vecs[9]  = mk(1'b1, 3'b000, 8'h44, 3'd0, L1, D1, E0, R1, 8'h00, dx(4'd1), 8'h44, 8'h00, 8'h00);
`ifdef CPU_STACK_GUARD_EN
        vecs[10] = mk(1'b0, 3'b101, 8'h00, 3'd0, LX, DX, EX, RX, 8'h44, 4'd1,     8'h44, 8'h00, 8'h00);
        vecs[11] = mk(1'b0, 3'b110, 8'h99, 3'd0, LX, DX, EX, RX, 8'h44, 4'd1,     8'h44, 8'h00, 8'h00);
`else
        vecs[10] = mk(1'b0, 3'b101, 8'h00, 3'd0, L1, D1, E0, R1, 8'h44, 4'd0,     8'h44, 8'h00, 8'h00);
        vecs[11] = mk(1'b0, 3'b110, 8'h99, 3'd0, L1, D1, E0, R1, 8'h44, 4'd0,     8'h99, 8'h00, 8'h00);
`endif

        bus.Valid = 1'b0; bus.Op = 3'd0; bus.Data = 8'h00; bus.Idx = 3'd0;
        do_reset();

        // Reset state
        chk("rst_ready",   {31'd0, bus.Ready},   32'd1);
        chk("rst_done",    {31'd0, bus.Done},    32'd0);
        chk("rst_error",   {31'd0, bus.Error},   32'd0);
        chk("rst_rddata",  {24'd0, bus.RdData},  32'd0);
        chk("rst_depth",   {28'd0, bus.Depth},   32'd0);
        chk("rst_latch",   {31'd0, bus.Latch},   32'd0);
        chk("rst_task",    {30'd0, bus.Task},    32'd0);
        chk("rst_address", {29'd0, bus.Address}, 32'd0);
        chk("rst_stackin", {24'd0, bus.StackIn}, 32'd0);

        // Table-driven operations
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst_first) do_reset();
            run_op(vecs[i].op, vecs[i].data, vecs[i].idx, lat_m, done_m, err_m, rdy_m, rd_got);
            chk($sformatf("v%0d_latch", i), {27'd0, lat_m},  {27'd0, vecs[i].lat});
            chk($sformatf("v%0d_done",  i), {27'd0, done_m}, {27'd0, vecs[i].done});
            chk($sformatf("v%0d_error", i), {27'd0, err_m},  {27'd0, vecs[i].err});
            chk($sformatf("v%0d_ready", i), {27'd0, rdy_m},  {27'd0, vecs[i].rdy});
            chk($sformatf("v%0d_rd",    i), {24'd0, rd_got}, {24'd0, vecs[i].rd});
            chk($sformatf("v%0d_depth", i), {28'd0, bus.Depth}, {28'd0, vecs[i].depth});
            chk($sformatf("v%0d_s0",    i), {24'd0, stk[0]}, {24'd0, vecs[i].s0});
            chk($sformatf("v%0d_s1",    i), {24'd0, stk[1]}, {24'd0, vecs[i].s1});
            chk($sformatf("v%0d_s2",    i), {24'd0, stk[2]}, {24'd0, vecs[i].s2});
        end

        // Nine pushes: the ninth overflows
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_op(3'b001, 8'(i + 1), 3'd0, lat_m, done_m, err_m, rdy_m, rd_got);
        end
        chk("push8_depth", {28'd0, bus.Depth}, {28'd0, dx(4'd8)});
        chk("push8_s0",    {24'd0, stk[0]},    32'h08);
        run_op(3'b001, 8'h09, 3'd0, lat_m, done_m, err_m, rdy_m, rd_got);
`ifdef CPU_STACK_GUARD_EN
        chk("push9_latch", {27'd0, lat_m},     {27'd0, LX});
        chk("push9_done",  {27'd0, done_m},    {27'd0, DX});
        chk("push9_error", {27'd0, err_m},     {27'd0, EX});
        chk("push9_depth", {28'd0, bus.Depth}, 32'd8);
        chk("push9_s0",    {24'd0, stk[0]},    32'h08);
        chk("push9_s7",    {24'd0, stk[7]},    32'h01);
`else
        chk("push9_latch", {27'd0, lat_m},     {27'd0, L1});
        chk("push9_done",  {27'd0, done_m},    {27'd0, D1});
        chk("push9_error", {27'd0, err_m},     {27'd0, E0});
        chk("push9_depth", {28'd0, bus.Depth}, 32'd0);
        chk("push9_s0",    {24'd0, stk[0]},    32'h09);
        chk("push9_s7",    {24'd0, stk[7]},    32'h02);
`endif

        // Reset asserted during ROT GAP1
        chk("rotrst_ready0", {31'd0, bus.Ready}, 32'd1);
        bus.Valid = 1'b1; bus.Op = 3'b111; bus.Data = 8'h00; bus.Idx = 3'd0;
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        chk("rotrst_latch1", {31'd0, bus.Latch}, 32'd1);
        @(posedge Clk); #1;
        chk("rotrst_gap_latch", {31'd0, bus.Latch}, 32'd0);
        chk("rotrst_gap_ready", {31'd0, bus.Ready}, 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rotrst_latch",  {31'd0, bus.Latch}, 32'd0);
        chk("rotrst_ready",  {31'd0, bus.Ready}, 32'd1);
        chk("rotrst_depth",  {28'd0, bus.Depth}, 32'd0);
        lat_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            if (bus.Latch === 1'b1) lat_cnt++;
        end
        chk("rotrst_no_second_latch", 32'(lat_cnt), 32'd0);
        chk("rotrst_done", {31'd0, bus.Done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
